// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle around the frame parser: UART receive side in, payload stream out.
// The parser takes the slave view; the receiver/consumer side takes the master view.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_last
    );

    modport master (
        output rx_data,
        output rx_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Framed-packet parser (SOF, LEN, payload, XOR checksum) behind a UART receiver; payload is
// released on a valid/ready stream only after the checksum passes. FRAME_LED_EN: leds show buf[0].
module uart_frame_parser #(
    parameter int         CLK_FREQ    = 50000000,
    parameter int         BAUD_RATE   = 9600,
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic                clk,
    input  logic                rst,
    uart_frame_parser_if.slave  bus,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic [7:0]          frame_cnt,
    output logic                busy,
    output logic [7:0]          leds
);

    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2 || CLK_FREQ < BAUD_RATE) begin : g_bad_param
        $error("uart_frame_parser: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    function automatic logic len_valid(input logic [7:0] l);
        return (l != 8'd0) && (l <= MAX_LEN_B);
    endfunction

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic [7:0]       len_q, len_d;
    logic [7:0]       chk_q, chk_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       pay_buf_q [MAX_LEN];
    logic             buf_we;

`ifdef FRAME_LED_EN
    logic [7:0]       leds_q, leds_d;
`endif

    logic       in_frame;
    logic       tmo_expired;
    logic       draining;
    logic       xfer;
    logic       at_last;
    logic [7:0] len_m1;

    assign len_m1      = len_q - 8'd1;
    assign in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_expired = in_frame && !bus.rx_valid && (tmo_q == TMO_LAST);
    assign draining    = (state_q == S_DRAIN);
    assign at_last     = (8'(rd_idx_q) == len_m1);
    assign xfer        = draining && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        len_d       = len_q;
        chk_d       = chk_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        buf_we      = 1'b0;
`ifdef FRAME_LED_EN
        leds_d      = leds_q;
`endif
        tmo_d       = (in_frame && !bus.rx_valid && !tmo_expired) ? tmo_q + TMO_W'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SOF_BYTE) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (bus.rx_valid) begin
                    if (len_valid(bus.rx_data)) begin
                        len_d    = bus.rx_data;
                        chk_d    = bus.rx_data;
                        wr_idx_d = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end
                end else if (tmo_expired) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end
            end

            S_PAYLOAD: begin
                if (bus.rx_valid) begin
                    buf_we   = 1'b1;
                    chk_d    = chk_q ^ bus.rx_data;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (8'(wr_idx_q) == len_m1) begin
                        state_d = S_CHK;
                    end
                end else if (tmo_expired) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end
            end

            S_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == chk_q) begin
                        frame_ok_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        rd_idx_d    = '0;
                        state_d     = S_DRAIN;
`ifdef FRAME_LED_EN
                        leds_d      = pay_buf_q[0];
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_IDLE;
                    end
                end else if (tmo_expired) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end
            end

            S_DRAIN: begin
                // Bytes arriving while the buffer is still draining are dropped, never parsed.
                if (bus.rx_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (xfer) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (at_last) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q    <= len_d;
        chk_q    <= chk_d;
        wr_idx_q <= wr_idx_d;
        rd_idx_q <= rd_idx_d;
        if (buf_we) begin
            pay_buf_q[wr_idx_q] <= bus.rx_data;
        end
    end

`ifdef FRAME_LED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= 8'd0;
        end else begin
            leds_q <= leds_d;
        end
    end
    assign leds = leds_q;
`else
    assign leds = frame_cnt_q;
`endif

    assign bus.out_valid = draining;
    assign bus.out_data  = draining ? pay_buf_q[rd_idx_q] : 8'd0;
    assign bus.out_last  = draining && at_last;

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: frame table plus hand-written backpressure,
// timeout, overrun and reset sequences; payload bytes are checked against a scoreboard queue.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_ok, frame_err, busy;
    logic [1:0] err_code;
    logic [7:0] frame_cnt, leds;

    always #5 clk = ~clk;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .CLK_FREQ   (50000000),
        .BAUD_RATE  (9600),
        .SOF_BYTE   (8'hA5),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .frame_cnt(frame_cnt),
        .busy     (busy),
        .leds     (leds)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_ok     = 0;
    int         n_err    = 0;
    logic [8:0] exp_q [$];
    logic [7:0] exp_cnt  = 8'd0;
    logic [7:0] exp_leds = 8'd0;

    typedef struct packed {
        logic [63:0] bytes;  // first byte in [63:56]
        logic [3:0]  n;
        logic [3:0]  sof;
        logic        ok;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic note_good(input logic [7:0] first_pay);
        exp_cnt = exp_cnt + 8'd1;
`ifdef FRAME_LED_EN
        exp_leds = first_pay;
`else
        exp_leds = exp_cnt;
`endif
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy && !bus.out_valid) break;
            @(negedge clk);
        end
        if (i >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout busy=%0d required=0", name, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: pulse counting, backpressure stability and payload scoreboard.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (frame_ok)  n_ok++;
            if (frame_err) n_err++;
            if (frame_ok || frame_err) check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
            if (prev_stall) begin
                check("bp_valid", 32'(bus.out_valid), 32'd1);
                check("bp_data",  32'(bus.out_data),  32'(prev_data));
                check("bp_last",  32'(bus.out_last),  32'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected got=%0h required=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'({bus.out_last, bus.out_data}), 32'(e));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ok0, err0, cnt;
        logic [7:0] b, ck;

        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{bytes: 64'hA503112233030000, n: 4'd6, sof: 4'd0, ok: 1'b1, code: 2'd0};
        vecs[1] = '{bytes: 64'hA502AABB00000000, n: 4'd5, sof: 4'd0, ok: 1'b0, code: 2'd1};
        vecs[2] = '{bytes: 64'hA500000000000000, n: 4'd2, sof: 4'd0, ok: 1'b0, code: 2'd0};
        vecs[3] = '{bytes: 64'hA511000000000000, n: 4'd2, sof: 4'd0, ok: 1'b0, code: 2'd0};
        vecs[4] = '{bytes: 64'hA5015A5B00000000, n: 4'd4, sof: 4'd0, ok: 1'b1, code: 2'd0};
        vecs[5] = '{bytes: 64'h33A5020102010000, n: 4'd6, sof: 4'd1, ok: 1'b1, code: 2'd0};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_frame_ok",  32'(frame_ok),      32'd0);
        check("rst_frame_err", 32'(frame_err),     32'd0);
        check("rst_err_code",  32'(err_code),      32'd0);
        check("rst_frame_cnt", 32'(frame_cnt),     32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_leds",      32'(leds),          32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            ok0  = n_ok;
            err0 = n_err;
            if (vecs[v].ok) begin
                for (int i = int'(vecs[v].sof) + 2; i < int'(vecs[v].n) - 1; i++) begin
                    b = vecs[v].bytes[63-8*i -: 8];
                    exp_q.push_back({(i == int'(vecs[v].n) - 2), b});
                end
                b = vecs[v].bytes[63-8*(int'(vecs[v].sof)+2) -: 8];
                note_good(b);
            end
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                send_byte(vecs[v].bytes[63-8*i -: 8]);
            end
            wait_idle($sformatf("v%0d", v));
            check($sformatf("v%0d_ok_pulses", v),  32'(n_ok - ok0),   vecs[v].ok ? 32'd1 : 32'd0);
            check($sformatf("v%0d_err_pulses", v), 32'(n_err - err0), vecs[v].ok ? 32'd0 : 32'd1);
            if (!vecs[v].ok) check($sformatf("v%0d_err_code", v), 32'(err_code), 32'(vecs[v].code));
            check($sformatf("v%0d_frame_cnt", v), 32'(frame_cnt), 32'(exp_cnt));
            check($sformatf("v%0d_leds", v),      32'(leds),      32'(exp_leds));
            check($sformatf("v%0d_busy", v),      32'(busy),      32'd0);
            check($sformatf("v%0d_queue", v),     32'(exp_q.size()), 32'd0);
        end

        // Backpressure: hold byte 22 for five cycles.
        ok0 = n_ok;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        note_good(8'h11);
        bus.out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        check("bp_first_data",  32'(bus.out_data),  32'h11);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_hold_start", 32'(bus.out_data), 32'h22);
        repeat (5) @(negedge clk);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_end",   32'(bus.out_data),  32'h22);
        bus.out_ready = 1'b1;
        wait_idle("bp");
        check("bp_ok_pulses", 32'(n_ok - ok0),   32'd1);
        check("bp_queue",     32'(exp_q.size()), 32'd0);
        check("bp_frame_cnt", 32'(frame_cnt),    32'(exp_cnt));

        // Maximum-length frame.
        ok0 = n_ok;
        ck  = 8'(MAX_LEN);
        send_byte(8'hA5);
        send_byte(8'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) begin
            b  = 8'(i * 13 + 5);
            ck = ck ^ b;
            exp_q.push_back({(i == MAX_LEN - 1), b});
            if (i == 0) note_good(b);
            send_byte(b);
        end
        send_byte(ck);
        wait_idle("maxlen");
        check("maxlen_ok_pulses", 32'(n_ok - ok0),   32'd1);
        check("maxlen_queue",     32'(exp_q.size()), 32'd0);
        check("maxlen_leds",      32'(leds),         32'(exp_leds));

        // Inter-byte timeout mid-payload, then a fresh frame.
        err0 = n_err;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        cnt = 0;
        while (cnt < TMO + 20) begin
            @(negedge clk);
            #1;
            cnt++;
            if (frame_err) break;
        end
        check("tmo_fired",    32'(frame_err), 32'd1);
        check("tmo_window",   32'(cnt >= TMO - 3 && cnt <= TMO + 1), 32'd1);
        check("tmo_err_code", 32'(err_code), 32'd2);
        @(negedge clk);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_err_pulses", 32'(n_err - err0), 32'd1);
        ok0 = n_ok;
        exp_q.push_back({1'b1, 8'h5A});
        note_good(8'h5A);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        wait_idle("tmo_next");
        check("tmo_next_ok", 32'(n_ok - ok0), 32'd1);

        // Overrun during a stalled drain; a dropped SOF must not start a frame.
        ok0  = n_ok;
        err0 = n_err;
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b1, 8'h3C});
        note_good(8'hC3);
        bus.out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFD);
        check("ovr_valid_before", 32'(bus.out_valid), 32'd1);
        send_byte(8'h77);
        check("ovr_err_pulses", 32'(n_err - err0), 32'd1);
        check("ovr_err_code",   32'(err_code),     32'd3);
        check("ovr_still_valid", 32'(bus.out_valid), 32'd1);
        check("ovr_data_held",  32'(bus.out_data),  32'hC3);
        send_byte(8'hA5);
        check("ovr_sof_err_pulses", 32'(n_err - err0), 32'd2);
        bus.out_ready = 1'b1;
        wait_idle("ovr");
        check("ovr_busy_after", 32'(busy),         32'd0);
        check("ovr_ok_pulses",  32'(n_ok - ok0),   32'd1);
        check("ovr_queue",      32'(exp_q.size()), 32'd0);

        // Reset mid-payload aborts silently.
        err0 = n_err;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mrst_busy",      32'(busy),          32'd0);
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_frame_cnt", 32'(frame_cnt),     32'd0);
        check("mrst_leds",      32'(leds),          32'd0);
        check("mrst_err_code",  32'(err_code),      32'd0);
        check("mrst_frame_err", 32'(frame_err),     32'd0);
        rst      = 1'b0;
        exp_cnt  = 8'd0;
        exp_leds = 8'd0;
        repeat (3) @(negedge clk);
        check("mrst_no_err", 32'(n_err - err0), 32'd0);
        ok0 = n_ok;
        exp_q.push_back({1'b1, 8'h5A});
        note_good(8'h5A);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        wait_idle("mrst_next");
        check("mrst_next_ok",  32'(n_ok - ok0), 32'd1);
        check("mrst_next_cnt", 32'(frame_cnt),  32'(exp_cnt));
        check("mrst_next_leds", 32'(leds),      32'(exp_leds));
        check("final_queue",   32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (rx_data/rx_valid) and recognises framed packets: SOF, LEN, payload, XOR checksum.
- Buffers the payload. Releases it on a valid/ready byte stream only after the checksum passes.
- Reports good and bad frames, and drives the board LEDs.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz (documentation and timeout derivation only)
- BAUD_RATE, 9600, line rate of the upstream receiver
- SOF_BYTE, 8'hA5, start-of-frame marker
- MAX_LEN, 16, maximum payload length in bytes (1..255)
- TIMEOUT_CYC, 200000, inter-byte timeout in clk cycles while mid-frame

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- out_data  out  8  payload byte
- out_valid  out  1  out_data valid
- out_last  out  1  marks the final payload byte of a frame
- out_ready  in  1  consumer accepts a byte when out_valid && out_ready
- frame_ok  out  1  one-cycle pulse: frame passed checksum
- frame_err  out  1  one-cycle pulse: frame or byte rejected
- err_code  out  2  0=bad LEN, 1=checksum, 2=timeout, 3=overrun; holds until the next error
- frame_cnt  out  8  count of good frames, wraps 255->0
- busy  out  1  high in any state other than IDLE
- leds  out  8  LED drive (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1): state=IDLE.
  - All outputs 0: out_*, frame_ok, frame_err, err_code, frame_cnt, busy, leds.
  - Timeout counter cleared. Buffer contents are don't-care.
  - Reset mid-frame or mid-drain aborts silently, with no frame_err pulse.
- FSM states: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE:
  - rx_valid with rx_data==SOF_BYTE -> LEN.
  - Any other byte is ignored, with no error.
- LEN (on rx_valid):
  - rx_data==0 or rx_data>MAX_LEN -> frame_err, err_code=0, go to IDLE.
  - Otherwise: len<=rx_data, chk<=rx_data, wr_idx<=0, go to PAYLOAD.
- PAYLOAD (on rx_valid):
  - buf[wr_idx]<=rx_data, chk<=chk^rx_data, wr_idx++.
  - When wr_idx==len-1 -> CHK.
- CHK (on rx_valid):
  - rx_data==chk -> DRAIN; frame_ok pulses the next cycle; frame_cnt increments the same cycle.
  - Mismatch -> frame_err, err_code=1, go to IDLE.
- Timeout:
  - Counter runs only in LEN/PAYLOAD/CHK and clears on every rx_valid.
  - Reaching TIMEOUT_CYC-1 -> frame_err, err_code=2, go to IDLE.
  - rx_valid in the same cycle as expiry wins; the byte is processed and the counter clears.
- DRAIN:
  - out_valid=1 and out_data=buf[rd_idx]; out_last=1 when rd_idx==len-1.
  - A transfer occurs on out_valid&&out_ready, then rd_idx++.
  - The transfer with out_last -> IDLE, with out_valid low the next cycle.
  - out_data/out_last stay stable while out_valid && !out_ready.
- Latency: first out_valid is asserted the cycle after the rx_valid cycle carrying the checksum byte, coincident with frame_ok.
- Overrun:
  - rx_valid in DRAIN -> byte dropped, frame_err, err_code=3; state stays DRAIN and the drain is unaffected.
  - A SOF dropped this way is not recognised.
- frame_ok and frame_err are never asserted in the same cycle (states are exclusive).

Optional Feature:
- Macro: FRAME_LED_EN.
- Defined: leds register loads the first payload byte (buf[0]) of each good frame, in the frame_ok cycle, and holds it.
- Undefined: leds = frame_cnt.

Test Plan:
- Good frame: send A5 03 11 22 33 03^11^22^33=03 with out_ready=1 ->
  - frame_ok single pulse; out stream 11,22,33 with out_last on 33.
  - frame_cnt=1; leds=11 (FRAME_LED_EN) or 01.
- Backpressure: same frame, out_ready low for 5 cycles on byte 22 -> out_data holds 22, out_valid stays high, no loss or duplication.
- Bad checksum: A5 02 AA BB 00 -> frame_err, err_code=1, no out_valid, frame_cnt unchanged, busy returns 0.
- Bad length: A5 00 and A5 11 (MAX_LEN=16) -> frame_err, err_code=0 each time. A following valid frame A5 01 5A 5B is accepted.
- Timeout: A5 02 10, then silence for TIMEOUT_CYC cycles -> frame_err, err_code=2, IDLE. A new SOF then starts a fresh frame.
- Overrun and reset: during DRAIN with out_ready=0, inject byte 77 -> frame_err, err_code=3, the drain then completes normally. Assert rst mid-PAYLOAD -> all outputs 0 next cycle, no frame_err.
